// File: rtl/ddr3_arbiter.sv
// Two-port round-robin arbiter in front of the ddr3_controller Avalon-MM local port.
// Single-beat reads/writes; a tag FIFO records which requester owns each outstanding read.
module ddr3_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  // Requester 0
  output logic                           rq0_ready,
  input  logic                           rq0_read,
  input  logic                           rq0_write,
  input  logic [ADDR_WIDTH-1:0]          rq0_addr,
  input  logic [DATA_WIDTH-1:0]          rq0_wdata,
  input  logic [DATA_WIDTH/8-1:0]        rq0_be,
  output logic                           rq0_rsp_valid,
  output logic [DATA_WIDTH-1:0]          rq0_rsp_data,
  // Requester 1
  output logic                           rq1_ready,
  input  logic                           rq1_read,
  input  logic                           rq1_write,
  input  logic [ADDR_WIDTH-1:0]          rq1_addr,
  input  logic [DATA_WIDTH-1:0]          rq1_wdata,
  input  logic [DATA_WIDTH/8-1:0]        rq1_be,
  output logic                           rq1_rsp_valid,
  output logic [DATA_WIDTH-1:0]          rq1_rsp_data,
  // Controller local port
  input  logic                           avl_ready,
  output logic                           avl_burstbegin,
  output logic                           avl_read_req,
  output logic                           avl_write_req,
  output logic [ADDR_WIDTH-1:0]          avl_addr,
  output logic [DATA_WIDTH-1:0]          avl_wdata,
  output logic [DATA_WIDTH/8-1:0]        avl_be,
  output logic [6:0]                     avl_size,
  input  logic                           avl_rdata_valid,
  input  logic [DATA_WIDTH-1:0]          avl_rdata,
  output logic                           tag_error,
  // Debug visibility
  output logic                           dbg_state_o,
  output logic [$clog2(TAG_DEPTH):0]     dbg_tag_count_o
);

  // Handshake: a requester holds read/write and its fields stable until rqN_ready is
  // high in a cycle; that cycle is the transfer. Toward the controller, a request is
  // taken in any ISSUE cycle where avl_ready is high.

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_owner_q, last_owner_d;

  logic [TAG_DEPTH-1:0]    tag_q;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic                    rsp_valid0_q, rsp_valid1_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    tag_error_q;

  logic                    fifo_full, fifo_empty;
  logic                    elig0, elig1;
  logic                    push, pop, head;

  logic                    sel_read, sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_be;

  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Reads may only be granted while a tag slot is free; writes never need one.
  assign elig0 = rq0_write | (rq0_read & ~fifo_full);
  assign elig1 = rq1_write | (rq1_read & ~fifo_full);

  assign sel_read  = owner_q ? rq1_read  : rq0_read;
  assign sel_write = owner_q ? rq1_write : rq0_write;
  assign sel_addr  = owner_q ? rq1_addr  : rq0_addr;
  assign sel_wdata = owner_q ? rq1_wdata : rq0_wdata;
  assign sel_be    = owner_q ? rq1_be    : rq0_be;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    push           = 1'b0;
    rq0_ready      = 1'b0;
    rq1_ready      = 1'b0;
    avl_burstbegin = 1'b0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_addr       = '0;
    avl_wdata      = '0;
    avl_be         = '0;
    case (state_q)
      ST_IDLE: begin
        if (elig0 && elig1) begin
          owner_d = ~last_owner_q;
          state_d = ST_ISSUE;
        end else if (elig0) begin
          owner_d = 1'b0;
          state_d = ST_ISSUE;
        end else if (elig1) begin
          owner_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        avl_read_req   = sel_read;
        avl_write_req  = sel_write;
        avl_burstbegin = sel_read | sel_write;
        avl_addr       = sel_addr;
        avl_wdata      = sel_wdata;
        avl_be         = sel_be;
        if (avl_ready) begin
          rq0_ready    = ~owner_q;
          rq1_ready    = owner_q;
          last_owner_d = owner_q;
          push         = sel_read;
          state_d      = ST_IDLE;
        end
      end
    endcase
  end

  // A pop is honoured whenever something is stored, including when full.
  assign pop  = avl_rdata_valid & ~fifo_empty;
  assign head = tag_q[rd_ptr_q];

  assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_data_q   <= '0;
      tag_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      if (push) tag_q[wr_ptr_q] <= owner_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_valid0_q <= pop & ~head;
      rsp_valid1_q <= pop & head;
      if (pop) rsp_data_q <= avl_rdata;
      // Data with no recorded owner cannot be routed; flag it until reset.
      if (avl_rdata_valid && fifo_empty) tag_error_q <= 1'b1;
    end
  end

  assign rq0_rsp_valid   = rsp_valid0_q;
  assign rq1_rsp_valid   = rsp_valid1_q;
  assign rq0_rsp_data    = rsp_data_q;
  assign rq1_rsp_data    = rsp_data_q;
  assign avl_size        = 7'd1;
  assign tag_error       = tag_error_q;
  assign dbg_state_o     = (state_q == ST_ISSUE);
  assign dbg_tag_count_o = count_q;

endmodule
